// File: rtl/cancel_message_encoder_pkg.sv
// Shared definitions for the cancel/delete message parser and encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cancel_message_encoder_pkg;

    // Operation codes carried on op_in
    localparam logic [2:0] OP_CANCEL = 3'd2;
    localparam logic [2:0] OP_DELETE = 3'd3;

    // Field widths in bytes, in wire order after the type byte
    localparam int MSG_TYPE        = 1;
    localparam int STOCK_LOCATE    = 2;
    localparam int TRACKING_NUMBER = 2;
    localparam int TIMESTAMP       = 6;
    localparam int ORDER_REF_NUM   = 8;
    localparam int SHARES          = 4;

    localparam int WORD_BYTES = 4;

    // Delete is the common prefix; cancel appends the shares field
    localparam int DELETE_BYTES = MSG_TYPE + STOCK_LOCATE + TRACKING_NUMBER
                                + TIMESTAMP + ORDER_REF_NUM;
    localparam int CANCEL_BYTES = DELETE_BYTES + SHARES;

    localparam int DELETE_WORDS = (DELETE_BYTES + WORD_BYTES - 1) / WORD_BYTES;
    localparam int CANCEL_WORDS = (CANCEL_BYTES + WORD_BYTES - 1) / WORD_BYTES;

    // The shift register holds the longest message
    localparam int SHIFT_BITS = CANCEL_BYTES * 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of meaningful bytes in the final word of an n-byte message
    function automatic logic [2:0] tail_bytes_for(input int nbytes);
        int rem;
        rem = nbytes % WORD_BYTES;
        return (rem == 0) ? 3'(WORD_BYTES) : 3'(rem);
    endfunction

endpackage

// File: rtl/cancel_message_encoder_if.sv
// Request fields and word stream of the cancel/delete encoder.
// Latency: n/a (signal bundle only).
// Backpressure: ready_in from the stream consumer stalls data_out.
interface cancel_message_encoder_if #(
    parameter int DATA_WIDTH = 31
);
    logic                  start_in;
    logic [2:0]            op_in;
    logic [15:0]           stock_locate_in;
    logic [15:0]           tracking_in;
    logic [47:0]           timestamp_in;
    logic [63:0]           order_ref_in;
    logic [31:0]           shares_in;

    logic [DATA_WIDTH:0]   data_out;
    logic                  valid_out;
    logic                  ready_in;
    logic                  last_out;
    logic [2:0]            bytes_valid_out;
    logic                  busy_out;
    logic                  done_out;
    logic                  err_out;

    // Encoder side: takes requests, drives the word stream
    modport master (
        input  start_in, op_in, stock_locate_in, tracking_in, timestamp_in,
               order_ref_in, shares_in, ready_in,
        output data_out, valid_out, last_out, bytes_valid_out,
               busy_out, done_out, err_out
    );

    // Requester/consumer side
    modport slave (
        output start_in, op_in, stock_locate_in, tracking_in, timestamp_in,
               order_ref_in, shares_in, ready_in,
        input  data_out, valid_out, last_out, bytes_valid_out,
               busy_out, done_out, err_out
    );

endinterface

// File: rtl/cancel_message_encoder.sv
// Serializes one order-cancel/delete request into big-endian 32-bit words.
// Latency: word 0 valid the cycle after start; done pulses the cycle after the last transfer.
// Backpressure: valid/ready; outputs hold while ready_in is low, start ignored while busy.
module cancel_message_encoder
    import cancel_message_encoder_pkg::*;
#(
    parameter int         DATA_WIDTH  = 31,
    parameter logic [7:0] CANCEL_CHAR = 8'h58,
    parameter logic [7:0] DELETE_CHAR = 8'h44
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    cancel_message_encoder_if.master bus
);

    localparam int WORD_BITS = DATA_WIDTH + 1;

    localparam logic [2:0] CANCEL_LAST_IDX = 3'(CANCEL_WORDS - 1);
    localparam logic [2:0] DELETE_LAST_IDX = 3'(DELETE_WORDS - 1);
    localparam logic [2:0] CANCEL_TAIL     = tail_bytes_for(CANCEL_BYTES);
    localparam logic [2:0] DELETE_TAIL     = tail_bytes_for(DELETE_BYTES);

    state_t                  state;
    logic [SHIFT_BITS-1:0]   shreg;
    logic [2:0]              word_cnt;
    logic [2:0]              tail_bytes;
    logic                    done_q;
    logic                    err_q;

    logic                    sending;
    logic                    on_last;

    assign sending = (state == SEND);
    assign on_last = sending && (word_cnt == 3'd0);

    // Capture the request into the shift register and walk it out one word per transfer
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state      <= IDLE;
            shreg      <= '0;
            word_cnt   <= '0;
            tail_bytes <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        if (bus.op_in == OP_CANCEL) begin
                            shreg      <= {CANCEL_CHAR, bus.stock_locate_in, bus.tracking_in,
                                           bus.timestamp_in, bus.order_ref_in, bus.shares_in};
                            word_cnt   <= CANCEL_LAST_IDX;
                            tail_bytes <= CANCEL_TAIL;
                            state      <= SEND;
                        end else if (bus.op_in == OP_DELETE) begin
                            // Shares slot is zero-filled so the pad bytes come out as 8'h00
                            shreg      <= {DELETE_CHAR, bus.stock_locate_in, bus.tracking_in,
                                           bus.timestamp_in, bus.order_ref_in,
                                           {(SHARES*8){1'b0}}};
                            word_cnt   <= DELETE_LAST_IDX;
                            tail_bytes <= DELETE_TAIL;
                            state      <= SEND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.ready_in) begin
                        // Shifting in zeros leaves the register clear after the last word
                        shreg <= {shreg[SHIFT_BITS-WORD_BITS-1:0], {WORD_BITS{1'b0}}};
                        if (word_cnt == 3'd0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte count of the presented word: full words until the tail
    always_comb begin
        bus.bytes_valid_out = 3'd0;
        if (on_last) begin
            bus.bytes_valid_out = tail_bytes;
        end else if (sending) begin
            bus.bytes_valid_out = 3'(WORD_BYTES);
        end
    end

    assign bus.data_out  = shreg[SHIFT_BITS-1 -: WORD_BITS];
    assign bus.valid_out = sending;
    assign bus.last_out  = on_last;
    assign bus.busy_out  = sending;
    assign bus.done_out  = done_q;
    assign bus.err_out   = err_q;

endmodule

// File: tb/tb_cancel_message_encoder.sv
// Self-checking bench for cancel_message_encoder.
// Latency: n/a.
// Backpressure: exercises ready_in stalls, both fixed and random.
module tb_cancel_message_encoder;
    import cancel_message_encoder_pkg::*;

    logic clk_in = 1'b0;
    logic reset_in;

    always #5 clk_in = ~clk_in;

    cancel_message_encoder_if bus ();

    cancel_message_encoder dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model output
    logic [31:0] exp_words[$];
    logic [2:0]  exp_tail;

    // Captured stream of the most recent message
    logic [31:0] got_words[$];
    bit          got_last[$];
    logic [2:0]  got_bv[$];
    int          hold_viol, err_seen, early_done, n_cycles;
    bit          timed_out, first_valid, done_ok;

    // Byte-level model: list fields big-endian, pad with zeros, pack four per word
    function automatic void build_expected(input logic [2:0] op, input logic [15:0] s,
                                           input logic [15:0] t, input logic [47:0] ts,
                                           input logic [63:0] o, input logic [31:0] sh);
        logic [7:0] q[$];
        int n;
        q.push_back(op == 3'd2 ? 8'h58 : 8'h44);
        for (int i = 1; i >= 0; i--) q.push_back(s[8*i +: 8]);
        for (int i = 1; i >= 0; i--) q.push_back(t[8*i +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(ts[8*i +: 8]);
        for (int i = 7; i >= 0; i--) q.push_back(o[8*i +: 8]);
        if (op == 3'd2) for (int i = 3; i >= 0; i--) q.push_back(sh[8*i +: 8]);
        n = q.size();
        exp_tail = 3'(n - 4 * ((n - 1) / 4));
        while (q.size() % 4 != 0) q.push_back(8'h00);
        exp_words.delete();
        for (int w = 0; w < q.size() / 4; w++)
            exp_words.push_back({q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]});
    endfunction

    task automatic random_fields();
        bus.op_in           = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
        bus.stock_locate_in = 16'($urandom);
        bus.tracking_in     = 16'($urandom);
        bus.timestamp_in    = 48'({$urandom, $urandom});
        bus.order_ref_in    = {$urandom, $urandom};
        bus.shares_in       = $urandom;
    endtask

    // Presents a request for one clock; returns at the negedge after it was sampled
    task automatic start_msg(input logic [2:0] op, input logic [15:0] s, input logic [15:0] t,
                             input logic [47:0] ts, input logic [63:0] o, input logic [31:0] sh);
        bus.op_in           = op;
        bus.stock_locate_in = s;
        bus.tracking_in     = t;
        bus.timestamp_in    = ts;
        bus.order_ref_in    = o;
        bus.shares_in       = sh;
        bus.start_in        = 1'b1;
        build_expected(op, s, t, ts, o, sh);
        @(negedge clk_in);
        bus.start_in = 1'b0;
    endtask

    // Consumes one message. mode 0: ready high, 1: random ready, 2: stall word 2 for 3 cycles.
    // poke_word >= 0 pulses start with new fields while that word is presented.
    // Returns at the negedge after the last transfer (the done cycle).
    task automatic drain(input int mode, input int poke_word);
        bit finished = 0, have_hold = 0, poked = 0, r;
        logic [31:0] hd;
        bit hl;
        logic [2:0] hb;
        int stall = 0;
        got_words.delete(); got_last.delete(); got_bv.delete();
        hold_viol = 0; err_seen = 0; early_done = 0; n_cycles = 0;
        timed_out = 0; done_ok = 0;
        first_valid = bus.valid_out;
        while (!finished && n_cycles < 300) begin
            if (bus.done_out) early_done++;
            if (bus.err_out) err_seen++;
            if (have_hold && (bus.valid_out !== 1'b1 || bus.data_out !== hd ||
                              bus.last_out !== hl || bus.bytes_valid_out !== hb))
                hold_viol++;
            case (mode)
                0: r = 1;
                1: r = ($urandom_range(0, 3) != 0);
                default: begin
                    r = !(got_words.size() == 2 && stall < 3);
                    if (!r) stall++;
                end
            endcase
            bus.ready_in = r;
            random_fields();
            if (poke_word >= 0 && !poked && got_words.size() == poke_word) begin
                bus.start_in = 1'b1;
                poked = 1;
            end else begin
                bus.start_in = 1'b0;
            end
            if (bus.valid_out === 1'b1) begin
                if (r) begin
                    got_words.push_back(bus.data_out);
                    got_last.push_back(bus.last_out);
                    got_bv.push_back(bus.bytes_valid_out);
                    have_hold = 0;
                    if (bus.last_out) finished = 1;
                end else begin
                    have_hold = 1;
                    hd = bus.data_out; hl = bus.last_out; hb = bus.bytes_valid_out;
                end
            end
            @(negedge clk_in);
            n_cycles++;
        end
        bus.start_in = 1'b0;
        bus.ready_in = 1'b0;
        timed_out = !finished;
        done_ok   = finished && (bus.done_out === 1'b1);
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        bus.start_in = 1'b0;
        bus.ready_in = 1'b0;
        random_fields();
        repeat (3) @(negedge clk_in);
        checks++;
        if (bus.data_out !== 32'h0) $display("FAIL reset_data got %h want 00000000", bus.data_out);
        else passed++;
        checks++;
        if ({bus.valid_out, bus.last_out, bus.bytes_valid_out, bus.busy_out, bus.done_out, bus.err_out} !== 8'h00)
            $display("FAIL reset_ctrl got v%b l%b bv%0d b%b d%b e%b want all 0", bus.valid_out,
                     bus.last_out, bus.bytes_valid_out, bus.busy_out, bus.done_out, bus.err_out);
        else passed++;
        reset_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_cancel();
        logic [31:0] ref_w [6] = '{32'h58010203, 32'h04050607, 32'h08090A0B,
                                   32'h0C0D0E0F, 32'h10111213, 32'h14151600};
        start_msg(3'd2, 16'h0102, 16'h0304, 48'h05060708090A, 64'h0B0C0D0E0F101112, 32'h13141516);
        drain(0, -1);
        checks++;
        if (first_valid !== 1'b1) $display("FAIL cancel_first_valid got %b want 1", first_valid); else passed++;
        checks++;
        if (got_words.size() != 6) $display("FAIL cancel_count got %0d want 6", got_words.size()); else passed++;
        for (int i = 0; i < 6 && i < got_words.size(); i++) begin
            checks++;
            if ({got_words[i], got_last[i], got_bv[i]} !== {ref_w[i], i == 5, (i == 5) ? 3'd3 : 3'd4})
                $display("FAIL cancel_word%0d got %h l%b bv%0d want %h l%b bv%0d", i, got_words[i],
                         got_last[i], got_bv[i], ref_w[i], i == 5, (i == 5) ? 3 : 4);
            else passed++;
        end
        checks++;
        if (n_cycles != 6 || !done_ok)
            $display("FAIL cancel_done_timing got cycles %0d done %b want 6 1", n_cycles, done_ok);
        else passed++;
        @(negedge clk_in);
        checks++;
        if ({bus.done_out, bus.busy_out, bus.valid_out} !== 3'b000)
            $display("FAIL cancel_after got d%b b%b v%b want 000", bus.done_out, bus.busy_out, bus.valid_out);
        else passed++;
    endtask

    task automatic test_delete();
        logic [31:0] ref_w [5] = '{32'h44010203, 32'h04050607, 32'h08090A0B,
                                   32'h0C0D0E0F, 32'h10111200};
        start_msg(3'd3, 16'h0102, 16'h0304, 48'h05060708090A, 64'h0B0C0D0E0F101112, 32'h13141516);
        drain(0, -1);
        checks++;
        if (got_words.size() != 5) $display("FAIL delete_count got %0d want 5", got_words.size()); else passed++;
        for (int i = 0; i < 5 && i < got_words.size(); i++) begin
            checks++;
            if ({got_words[i], got_last[i], got_bv[i]} !== {ref_w[i], i == 4, (i == 4) ? 3'd3 : 3'd4})
                $display("FAIL delete_word%0d got %h l%b bv%0d want %h l%b bv%0d", i, got_words[i],
                         got_last[i], got_bv[i], ref_w[i], i == 4, (i == 4) ? 3 : 4);
            else passed++;
        end
        checks++;
        if (n_cycles != 5 || !done_ok)
            $display("FAIL delete_done_timing got cycles %0d done %b want 5 1", n_cycles, done_ok);
        else passed++;
        @(negedge clk_in);
    endtask

    task automatic test_backpressure();
        logic [31:0] ref_w [6] = '{32'h58010203, 32'h04050607, 32'h08090A0B,
                                   32'h0C0D0E0F, 32'h10111213, 32'h14151600};
        start_msg(3'd2, 16'h0102, 16'h0304, 48'h05060708090A, 64'h0B0C0D0E0F101112, 32'h13141516);
        drain(2, -1);
        checks++;
        if (hold_viol != 0) $display("FAIL bp_hold got %0d unstable cycles want 0", hold_viol); else passed++;
        checks++;
        if (got_words.size() != 6) $display("FAIL bp_count got %0d want 6", got_words.size()); else passed++;
        for (int i = 0; i < 6 && i < got_words.size(); i++) begin
            checks++;
            if (got_words[i] !== ref_w[i]) $display("FAIL bp_word%0d got %h want %h", i, got_words[i], ref_w[i]);
            else passed++;
        end
        checks++;
        if (n_cycles != 9 || !done_ok)
            $display("FAIL bp_done_timing got cycles %0d done %b want 9 1", n_cycles, done_ok);
        else passed++;
        @(negedge clk_in);
    endtask

    task automatic test_illegal_op();
        int errs = 0, vis = 0;
        bus.op_in = 3'd5;
        bus.start_in = 1'b1;
        @(negedge clk_in);
        bus.start_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.err_out === 1'b1) errs++;
            if (bus.valid_out !== 1'b0 || bus.busy_out !== 1'b0) vis++;
            if (i == 0) begin
                checks++;
                if (bus.err_out !== 1'b1) $display("FAIL illegal_err_pulse got %b want 1", bus.err_out);
                else passed++;
            end
            @(negedge clk_in);
        end
        checks++;
        if (errs != 1) $display("FAIL illegal_err_count got %0d want 1", errs); else passed++;
        checks++;
        if (vis != 0) $display("FAIL illegal_idle got %0d active cycles want 0", vis); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ref_c [6] = '{32'h58010203, 32'h04050607, 32'h08090A0B,
                                   32'h0C0D0E0F, 32'h10111213, 32'h14151600};
        logic [31:0] ref_d [5] = '{32'h44A1A2A3, 32'hA4A5A6A7, 32'hA8A9AAAB,
                                   32'hACADAEAF, 32'hB0B1B200};
        start_msg(3'd2, 16'h0102, 16'h0304, 48'h05060708090A, 64'h0B0C0D0E0F101112, 32'h13141516);
        drain(0, 1);
        checks++;
        if (err_seen != 0 || early_done != 0)
            $display("FAIL b2b_ignored_start got err %0d early_done %0d want 0 0", err_seen, early_done);
        else passed++;
        checks++;
        if (got_words.size() != 6) $display("FAIL b2b_cancel_count got %0d want 6", got_words.size()); else passed++;
        for (int i = 0; i < 6 && i < got_words.size(); i++) begin
            checks++;
            if (got_words[i] !== ref_c[i]) $display("FAIL b2b_cancel_word%0d got %h want %h", i, got_words[i], ref_c[i]);
            else passed++;
        end
        checks++;
        if (!done_ok) $display("FAIL b2b_cancel_done got %b want 1", done_ok); else passed++;
        // Start in the done cycle
        start_msg(3'd3, 16'hA1A2, 16'hA3A4, 48'hA5A6A7A8A9AA, 64'hABACADAEAFB0B1B2, 32'hDEADBEEF);
        drain(0, -1);
        checks++;
        if (first_valid !== 1'b1) $display("FAIL b2b_delete_first_valid got %b want 1", first_valid); else passed++;
        checks++;
        if (got_words.size() != 5) $display("FAIL b2b_delete_count got %0d want 5", got_words.size()); else passed++;
        for (int i = 0; i < 5 && i < got_words.size(); i++) begin
            checks++;
            if (got_words[i] !== ref_d[i]) $display("FAIL b2b_delete_word%0d got %h want %h", i, got_words[i], ref_d[i]);
            else passed++;
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid_message();
        int dones = 0;
        start_msg(3'd2, 16'h0102, 16'h0304, 48'h05060708090A, 64'h0B0C0D0E0F101112, 32'h13141516);
        bus.ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++;
        if (bus.data_out !== 32'h0C0D0E0F) $display("FAIL rst_mid_word3 got %h want 0C0D0E0F", bus.data_out);
        else passed++;
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        bus.ready_in = 1'b0;
        checks++;
        if ({bus.valid_out, bus.busy_out} !== 2'b00)
            $display("FAIL rst_mid_valid got v%b b%b want 00", bus.valid_out, bus.busy_out);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            if (bus.done_out === 1'b1) dones++;
            @(negedge clk_in);
        end
        checks++;
        if (dones != 0) $display("FAIL rst_mid_no_done got %0d pulses want 0", dones); else passed++;
        start_msg(3'd2, 16'h1111, 16'h2222, 48'h333344445555, 64'h6666777788889999, 32'hAAAABBBB);
        drain(1, -1);
        checks++;
        if (got_words.size() != exp_words.size())
            $display("FAIL rst_mid_after_count got %0d want %0d", got_words.size(), exp_words.size());
        else passed++;
        for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
            checks++;
            if (got_words[i] !== exp_words[i])
                $display("FAIL rst_mid_after_word%0d got %h want %h", i, got_words[i], exp_words[i]);
            else passed++;
        end
        @(negedge clk_in);
    endtask

    task automatic test_random();
        int bad;
        for (int m = 0; m < 20; m++) begin
            start_msg(($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3, 16'($urandom), 16'($urandom),
                      48'({$urandom, $urandom}), {$urandom, $urandom}, $urandom);
            drain(1, -1);
            bad = 0;
            if (got_words.size() != exp_words.size()) bad++;
            for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
                if (got_words[i] !== exp_words[i]) bad++;
                if (got_last[i] !== (i == exp_words.size() - 1)) bad++;
                if (got_bv[i] !== ((i == exp_words.size() - 1) ? exp_tail : 3'd4)) bad++;
            end
            checks++;
            if (bad != 0 || timed_out)
                $display("FAIL rand_msg%0d got %0d bad fields, %0d words, timeout %b want 0, %0d, 0",
                         m, bad, got_words.size(), timed_out, exp_words.size());
            else passed++;
            checks++;
            if (hold_viol != 0 || !done_ok)
                $display("FAIL rand_flow%0d got hold_viol %0d done %b want 0 1", m, hold_viol, done_ok);
            else passed++;
            if ($urandom_range(0, 1) == 1) @(negedge clk_in);
        end
        @(negedge clk_in);
    endtask

    initial begin
        reset_in = 1'b1;
        bus.start_in = 1'b0;
        bus.ready_in = 1'b0;
        random_fields();
        @(negedge clk_in);
        test_reset();
        test_cancel();
        test_delete();
        test_backpressure();
        test_illegal_op();
        test_back_to_back();
        test_reset_mid_message();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
